// File: rtl/extractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extractor_pkg
// Description : Shared types, widths and helpers for the extractor job
//               controller and its response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package extractor_pkg;

    localparam int EXT_DATA_W = 16;
    localparam int EXT_BW_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Low-bit mask for a value width; a full-width value yields all ones.
    function automatic logic [EXT_DATA_W-1:0] bw_to_mask(input logic [EXT_BW_W-1:0] bw);
        logic [EXT_DATA_W:0] w_wide;
        w_wide = ((EXT_DATA_W+1)'(1) << bw) - (EXT_DATA_W+1)'(1);
        return w_wide[EXT_DATA_W-1:0];
    endfunction

endpackage : extractor_pkg
`default_nettype wire

// File: rtl/extractor_job_controller_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fifo
// Description : Synchronous FIFO with occupancy count and flush, used as the
//               memory response buffer of the extractor job controller.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule : ctrl_fifo
`default_nettype wire

// File: rtl/extractor_job_controller.sv
`default_nettype none
// ============================================================================
// Module      : extractor_job_controller
// Description : Runs one quantized-tensor job through an extractor: derives
//               its configuration, streams packed words from memory through a
//               credit-limited buffer and counts the emitted values.
//               Optional EXTRACTOR_CTRL_PERF_EN adds the perf_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module extractor_job_controller
    import extractor_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [ADDR_WIDTH-1:0]  job_addr,
    input  logic [31:0]            job_num_vals,
    input  logic [EXT_BW_W-1:0]    job_bitwidth,
    output logic                   job_done,
    output logic                   job_err,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [EXT_DATA_W-1:0]  mem_rsp_data,
    output logic                   ext_rstn,
    output logic [EXT_BW_W-1:0]    ext_bitwidth,
    output logic [EXT_DATA_W-1:0]  ext_mask,
    output logic [31:0]            ext_num_vals,
    output logic                   ext_rcv_valid,
    output logic [EXT_DATA_W-1:0]  ext_rcv_data,
    input  logic                   ext_rcv_ready,
`ifdef EXTRACTOR_CTRL_PERF_EN
    output logic [31:0]            perf_cycles,
`endif
    input  logic                   ext_trm_valid,
    input  logic                   ext_trm_ready
);

    localparam int CW = $clog2(FIFO_DEPTH);

    ctrl_state_e            r_state;
    logic                   r_alive;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [31:0]            r_num;
    logic [EXT_BW_W-1:0]    r_bw;
    logic                   r_err;
    logic [32:0]            r_words_total;
    logic [32:0]            r_issued;
    logic [32:0]            r_delivered;
    logic [CW:0]            r_outstanding;
    logic [31:0]            r_vals;
    logic [EXT_DATA_W-1:0]  r_ext_mask;
    logic [EXT_BW_W-1:0]    r_ext_bw;
    logic [31:0]            r_ext_num;

    logic                   w_job_fire;
    logic                   w_job_illegal;
    logic [35:0]            w_product;
    logic [32:0]            w_words_ceil;
    logic [32:0]            w_words_total;
    logic                   w_credit_ok;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_rsp_dec;
    logic                   w_in_run;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_pad;
    logic                   w_trm_fire;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic [CW:0]            w_fifo_count;
    logic [EXT_DATA_W-1:0]  w_fifo_data;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_job_fire    = job_valid && job_ready;
    assign w_job_illegal = (job_bitwidth == '0) || (job_bitwidth > EXT_BW_W'(16)) ||
                           (job_num_vals == '0);

    // Packed words needed, rounded up; the extractor always primes on two words.
    assign w_product     = 36'(r_num) * 36'(r_bw);
    assign w_words_ceil  = 33'((w_product + 36'd15) >> 4);
    assign w_words_total = (w_words_ceil < 33'd2) ? 33'd2 : w_words_ceil;

    // A request is only issued when a buffer slot is guaranteed for its response.
    assign w_credit_ok   = (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW+2)'(FIFO_DEPTH));
    assign w_req_valid   = w_in_run && (r_issued < r_words_total) && w_credit_ok;
    assign w_req_fire    = w_req_valid && mem_req_ready;
    assign w_rsp_dec     = mem_rsp_valid && (r_outstanding != '0);
    assign w_push        = mem_rsp_valid && w_in_run;
    assign w_pad         = (r_delivered >= r_words_total);
    assign w_pop         = w_in_run && ext_rcv_ready && !w_fifo_empty;
    assign w_trm_fire    = w_in_run && ext_trm_valid && ext_trm_ready;

    assign job_ready     = (r_state == ST_IDLE) && r_alive;
    assign job_done      = (r_state == ST_DONE);
    assign job_err       = (r_state == ST_DONE) && r_err;
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_addr + ADDR_WIDTH'({r_issued, 1'b0});
    assign ext_rstn      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign ext_bitwidth  = r_ext_bw;
    assign ext_mask      = r_ext_mask;
    assign ext_num_vals  = r_ext_num;
    assign ext_rcv_valid = w_in_run && (!w_fifo_empty || w_pad);
    assign ext_rcv_data  = w_fifo_empty ? '0 : w_fifo_data;

    ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EXT_DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (!w_in_run),
        .push      (w_push),
        .push_data (mem_rsp_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_alive       <= 1'b0;
            r_addr        <= '0;
            r_num         <= '0;
            r_bw          <= '0;
            r_err         <= 1'b0;
            r_words_total <= '0;
            r_issued      <= '0;
            r_delivered   <= '0;
            r_outstanding <= '0;
            r_vals        <= '0;
            r_ext_mask    <= '0;
            r_ext_bw      <= '0;
            r_ext_num     <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_job_fire) begin
                        r_addr  <= job_addr;
                        r_num   <= job_num_vals;
                        r_bw    <= job_bitwidth;
                        r_err   <= w_job_illegal;
                        r_state <= w_job_illegal ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_ext_mask    <= bw_to_mask(r_bw);
                    r_ext_bw      <= r_bw;
                    r_ext_num     <= r_num;
                    r_words_total <= w_words_total;
                    r_issued      <= '0;
                    r_delivered   <= '0;
                    r_vals        <= '0;
                    r_state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_req_fire) r_issued    <= r_issued + 33'd1;
                    if (w_pop)      r_delivered <= r_delivered + 33'd1;
                    if (w_trm_fire) r_vals      <= r_vals + 32'd1;
                    if (r_vals == r_num) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (r_state == ST_LOAD) begin
                r_outstanding <= '0;
            end else begin
                case ({w_req_fire, w_rsp_dec})
                    2'b10:   r_outstanding <= r_outstanding + (CW+1)'(1);
                    2'b01:   r_outstanding <= r_outstanding - (CW+1)'(1);
                    default: r_outstanding <= r_outstanding;
                endcase
            end
        end
    end

`ifdef EXTRACTOR_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;

    assign perf_cycles = r_perf_cycles;

    // Spans LOAD through DONE inclusive and holds until the next job loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
        end else if (r_state == ST_LOAD) begin
            r_perf_cycles <= 32'd1;
        end else if ((r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_DONE)) begin
            if (r_perf_cycles != 32'hFFFF_FFFF) r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end
`endif

endmodule : extractor_job_controller
`default_nettype wire
